// File: rtl/la_wb_pkg.sv
// rtl/la_wb_pkg.sv - shared constants and byte-lane helpers for the LA Wishbone capture block
package la_wb_pkg;

  localparam int WB_DW = 32;

  localparam logic [3:0] BANK_DATA  = 4'd0;
  localparam logic [3:0] BANK_OENB  = 4'd1;
  localparam logic [3:0] BANK_IENA  = 4'd2;
  localparam logic [3:0] BANK_IN    = 4'd3;
  localparam logic [3:0] BANK_EDGE  = 4'd4;
  localparam logic [3:0] BANK_IRQEN = 4'd5;

  localparam int ADR_BANK_LSB = 8;
  localparam int ADR_WORD_LSB = 2;

  // Expand the four byte-lane selects into a 32-bit bit mask.
  function automatic logic [WB_DW-1:0] byte_mask(input logic [3:0] sel);
    logic [WB_DW-1:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  // Replace only the selected byte lanes of old_w with new_w.
  function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0] old_w,
                                                  input logic [WB_DW-1:0] new_w,
                                                  input logic [3:0]       sel);
    logic [WB_DW-1:0] m;
    m = byte_mask(sel);
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/la_wb_cap_if.sv
// rtl/la_wb_cap_if.sv - Wishbone slave bus bundle for the LA capture block
interface la_wb_cap_if;
  import la_wb_pkg::*;

  logic             wb_stb_i;
  logic             wb_cyc_i;
  logic             wb_we_i;
  logic [3:0]       wb_sel_i;
  logic [WB_DW-1:0] wb_adr_i;
  logic [WB_DW-1:0] wb_dat_i;
  logic             wb_ack_o;
  logic [WB_DW-1:0] wb_dat_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

endinterface

// File: rtl/la_sync_edge.sv
// rtl/la_sync_edge.sv - input synchroniser, enable gating and rising-edge detect
module la_sync_edge #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] async_i,
  input  logic [WIDTH-1:0] ena_i,
  output logic [WIDTH-1:0] in_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // Gating after the synchroniser means a disabled bit reads 0 and can never edge.
  assign in_o   = sync_q[STAGES-1] & ena_i;
  assign rise_o = in_o & ~prev_q;

  // Metastability chain plus one-cycle history of the gated sample.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= in_o;
    end
  end

endmodule

// File: rtl/la_wb_cap.sv
// rtl/la_wb_cap.sv - parametrised LA Wishbone slave with input capture, sticky edges and interrupt
module la_wb_cap
  import la_wb_pkg::*;
#(
  parameter int          LA_WIDTH    = 128,
  parameter logic [31:0] BASE_ADR    = 32'h2200_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  la_wb_cap_if.slave          wb,
  input  logic [LA_WIDTH-1:0] la_data_in,
  output logic [LA_WIDTH-1:0] la_data_o,
  output logic [LA_WIDTH-1:0] la_oenb_o,
  output logic [LA_WIDTH-1:0] la_iena_o,
  output logic                irq_o
);

  localparam int NWORDS = LA_WIDTH / 32;

  logic [LA_WIDTH-1:0] data_q, data_d;
  logic [LA_WIDTH-1:0] oenb_q, oenb_d;
  logic [LA_WIDTH-1:0] iena_q, iena_d;
  logic [LA_WIDTH-1:0] edge_q, edge_d;
  logic [LA_WIDTH-1:0] irqen_q, irqen_d;
  logic [LA_WIDTH-1:0] edge_clr;
  logic [LA_WIDTH-1:0] in_w;
  logic [LA_WIDTH-1:0] rise_w;
  logic                ack_q, ack_d;
  logic [WB_DW-1:0]    dat_q, dat_d;
  logic                irq_q, irq_d;
  logic [WB_DW-1:0]    rdata;

  logic       hit;
  logic       accept;
  logic       wr;
  logic [3:0] bank;
  logic [5:0] word;
  logic       unused_adr;

  assign hit        = (wb.wb_adr_i[31:12] == BASE_ADR[31:12]);
  assign bank       = wb.wb_adr_i[ADR_BANK_LSB +: 4];
  assign word       = wb.wb_adr_i[ADR_WORD_LSB +: 6];
  assign unused_adr = ^wb.wb_adr_i[1:0];
  // Blocking on ack_q forces the mandatory idle cycle between accesses.
  assign accept     = wb.wb_stb_i & wb.wb_cyc_i & hit & ~ack_q;
  assign wr         = accept & wb.wb_we_i;

  la_sync_edge #(
    .WIDTH  (LA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (wb_clk_i),
    .rstn_i  (wb_rst_i),
    .async_i (la_data_in),
    .ena_i   (iena_q),
    .in_o    (in_w),
    .rise_o  (rise_w)
  );

  // Word/bank decode for read mux and byte-masked register writes; unmapped slots fall through to 0.
  always_comb begin
    data_d   = data_q;
    oenb_d   = oenb_q;
    iena_d   = iena_q;
    irqen_d  = irqen_q;
    edge_clr = '0;
    rdata    = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (word == 6'(k)) begin
        case (bank)
          BANK_DATA:  rdata = data_q[32*k +: 32];
          BANK_OENB:  rdata = oenb_q[32*k +: 32];
          BANK_IENA:  rdata = iena_q[32*k +: 32];
          BANK_IN:    rdata = in_w[32*k +: 32];
          BANK_EDGE:  rdata = edge_q[32*k +: 32];
          BANK_IRQEN: rdata = irqen_q[32*k +: 32];
          default:    rdata = '0;
        endcase
        if (wr) begin
          case (bank)
            BANK_DATA:  data_d[32*k +: 32]   = byte_merge(data_q[32*k +: 32], wb.wb_dat_i, wb.wb_sel_i);
            BANK_OENB:  oenb_d[32*k +: 32]   = byte_merge(oenb_q[32*k +: 32], wb.wb_dat_i, wb.wb_sel_i);
            BANK_IENA:  iena_d[32*k +: 32]   = byte_merge(iena_q[32*k +: 32], wb.wb_dat_i, wb.wb_sel_i);
            BANK_EDGE:  edge_clr[32*k +: 32] = wb.wb_dat_i & byte_mask(wb.wb_sel_i);
            BANK_IRQEN: irqen_d[32*k +: 32]  = byte_merge(irqen_q[32*k +: 32], wb.wb_dat_i, wb.wb_sel_i);
            default:    ;
          endcase
        end
      end
    end
    // OR-ing the new rise after the clear lets a simultaneous edge win over W1C.
    edge_d = (edge_q & ~edge_clr) | rise_w;
    ack_d  = accept;
    dat_d  = (accept && !wb.wb_we_i) ? rdata : '0;
    irq_d  = |(edge_q & irqen_q);
  end

  // All architectural state, including the pending ack, is discarded on reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      data_q  <= '0;
      oenb_q  <= '1;
      iena_q  <= '0;
      edge_q  <= '0;
      irqen_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      oenb_q  <= oenb_d;
      iena_q  <= iena_d;
      edge_q  <= edge_d;
      irqen_q <= irqen_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign la_data_o   = data_q;
  assign la_oenb_o   = oenb_q;
  assign la_iena_o   = iena_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_la_wb_cap.sv
// tb/tb_la_wb_cap.sv - scoreboard bench for la_wb_cap
module tb_la_wb_cap;
  import la_wb_pkg::*;

  localparam int          LA_W = 128;
  localparam int          NW   = LA_W / 32;
  localparam logic [31:0] BASE = 32'h2200_0000;

  logic            clk = 1'b0;
  logic            rstn;
  logic [LA_W-1:0] la_in;
  logic [LA_W-1:0] la_data;
  logic [LA_W-1:0] la_oenb;
  logic [LA_W-1:0] la_iena;
  logic            irq;
  logic [LA_W-1:0] la_snap;
  logic [31:0]     exp_q [$];
  int              n_checks = 0;
  int              n_fail   = 0;

  la_wb_cap_if bus ();

  la_wb_cap #(
    .LA_WIDTH    (LA_W),
    .BASE_ADR    (BASE),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rstn),
    .wb         (bus),
    .la_data_in (la_in),
    .la_data_o  (la_data),
    .la_oenb_o  (la_oenb),
    .la_iena_o  (la_iena),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] adr(input int bank, input int word);
    return BASE | (32'(bank) << 8) | (32'(word) << 2);
  endfunction

  task automatic bus_idle();
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
  endtask

  // One access; returns at the negedge where ack was seen (or after 20 cycles without ack).
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] sel, output logic [31:0] rd, output bit got);
    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o === 1'b1) begin
        got     = 1'b1;
        rd      = bus.wb_dat_o;
        la_snap = la_data | 0;
        la_snap = (we && bank_of(a) == 1) ? la_oenb : (we && bank_of(a) == 2) ? la_iena : la_data;
        break;
      end
    end
    bus_idle();
  endtask

  function automatic int bank_of(input logic [31:0] a);
    return int'(a[11:8]);
  endfunction

  task automatic test_reset();
    logic [31:0] rd, e;
    bit got;
    rstn  = 1'b0;
    la_in = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: ack=%b dat=%h irq=%b required 0/0/0", bus.wb_ack_o, bus.wb_dat_o, irq);
    end
    n_checks++;
    if (la_data !== '0 || la_oenb !== '1 || la_iena !== '0) begin
      n_fail++;
      $display("FAIL reset_la: data=%h oenb=%h iena=%h required 0/all-ones/0", la_data, la_oenb, la_iena);
    end
    rstn = 1'b1;
    for (int w = 0; w < NW; w += NW - 1) begin
      for (int b = 0; b < 6; b++) begin
        exp_q.push_back((b == 1) ? 32'hFFFF_FFFF : 32'h0);
        xfer(1'b0, adr(b, w), 32'h0, 4'hF, rd, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== e) begin
          n_fail++;
          $display("FAIL reset_read bank%0d word%0d: got=%h ack=%b required %h", b, w, rd, got, e);
        end
        @(negedge clk);
        n_checks++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
          n_fail++;
          $display("FAIL ack_pulse bank%0d word%0d: ack=%b dat=%h required 0/0", b, w, bus.wb_ack_o, bus.wb_dat_o);
        end
      end
    end
  endtask

  task automatic test_write_sel();
    logic [31:0] rd, e;
    bit got;
    xfer(1'b1, adr(0, 3), 32'hDEAD_BEEF, 4'b0101, rd, got);
    n_checks++;
    if (!got || la_snap[127:96] !== 32'h00AD_00EF || la_snap[95:0] !== '0) begin
      n_fail++;
      $display("FAIL data_pins_at_ack: got=%h ack=%b required 00ad00ef", la_snap[127:96], got);
    end
    exp_q.push_back(32'h00AD_00EF);
    xfer(1'b0, adr(0, 3), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL data_readback: got=%h required %h", rd, e);
    end
    xfer(1'b1, adr(1, 1), 32'h1234_5678, 4'hF, rd, got);
    n_checks++;
    if (!got || la_snap[63:32] !== 32'h1234_5678 || la_snap[31:0] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL oenb_pins_at_ack: got=%h required ffffffff12345678", la_snap[63:0]);
    end
    exp_q.push_back(32'h1234_5678);
    xfer(1'b0, adr(1, 1), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL oenb_readback: got=%h required %h", rd, e);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd, e;
    bit got;
    xfer(1'b1, adr(2, 0), 32'h1, 4'hF, rd, got);
    n_checks++;
    if (!got || la_snap[31:0] !== 32'h1) begin
      n_fail++;
      $display("FAIL iena_pins: got=%h required 00000001", la_snap[31:0]);
    end
    la_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    for (int b = 3; b <= 4; b++) begin
      exp_q.push_back(32'h1);
      xfer(1'b0, adr(b, 0), 32'h0, 4'hF, rd, got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || rd !== e) begin
        n_fail++;
        $display("FAIL edge_capture bank%0d: got=%h required %h", b, rd, e);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked: irq=%b required 0", irq);
    end
    xfer(1'b1, adr(5, 0), 32'h1, 4'hF, rd, got);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_at_irqen_ack: irq=%b required 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_after_irqen: irq=%b required 1", irq);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd, e;
    bit got;
    la_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    la_in[0] = 1'b1;
    @(negedge clk);
    xfer(1'b1, adr(4, 0), 32'h1, 4'hF, rd, got);
    exp_q.push_back(32'h1);
    xfer(1'b0, adr(4, 0), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL set_beats_clear: got=%h required %h", rd, e);
    end
    xfer(1'b1, adr(4, 0), 32'h1, 4'hF, rd, got);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_at_clear_ack: irq=%b required 1", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_after_clear: irq=%b required 0", irq);
    end
    exp_q.push_back(32'h0);
    xfer(1'b0, adr(4, 0), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL w1c_clear: got=%h required %h", rd, e);
    end
    la_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    la_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_latency_early: irq=%b required 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_latency: irq=%b required 1", irq);
    end
  endtask

  task automatic test_iena_off();
    logic [31:0] rd, e;
    bit got;
    xfer(1'b1, adr(4, 0), 32'hFFFF_FFFF, 4'hF, rd, got);
    xfer(1'b1, adr(2, 0), 32'h0, 4'hF, rd, got);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      la_in = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (4) @(negedge clk);
    for (int b = 3; b <= 4; b++) begin
      for (int w = 0; w < NW; w += 2) begin
        exp_q.push_back(32'h0);
        xfer(1'b0, adr(b, w), 32'h0, 4'hF, rd, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || rd !== e) begin
          n_fail++;
          $display("FAIL iena_off bank%0d word%0d: got=%h required %h", b, w, rd, e);
        end
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL iena_off_irq: irq=%b required 0", irq);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd, e;
    bit got;
    xfer(1'b1, adr(0, 0), 32'hA5A5_A5A5, 4'hF, rd, got);
    xfer(1'b1, adr(7, 0), 32'hFFFF_FFFF, 4'hF, rd, got);
    xfer(1'b1, adr(0, NW), 32'hFFFF_FFFF, 4'hF, rd, got);
    exp_q.push_back(32'h0);
    xfer(1'b0, adr(6, 0), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL unmapped_bank: got=%h ack=%b required %h with ack", rd, got, e);
    end
    exp_q.push_back(32'h0);
    xfer(1'b0, adr(0, NW), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL unmapped_word: got=%h ack=%b required %h with ack", rd, got, e);
    end
    exp_q.push_back(32'hA5A5_A5A5);
    xfer(1'b0, adr(0, 0), 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || rd !== e) begin
      n_fail++;
      $display("FAIL unmapped_write_ignored: got=%h required %h", rd, e);
    end
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, got);
    n_checks++;
    if (got) begin
      n_fail++;
      $display("FAIL non_hit_ack: ack=%b required no ack", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e;
    bit got;
    @(negedge clk);
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = adr(0, 1);
    bus.wb_dat_i = 32'hFFFF_FFFF;
    rstn         = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.wb_ack_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_ack cycle%0d: ack=%b required 0", i, bus.wb_ack_o);
      end
    end
    bus_idle();
    rstn = 1'b1;
    n_checks++;
    if (la_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_pins: data=%h required 0", la_data);
    end
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back(32'h0);
      xfer(1'b0, adr(0, w), 32'h0, 4'hF, rd, got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || rd !== e) begin
        n_fail++;
        $display("FAIL reset_mid_data word%0d: got=%h required %h", w, rd, e);
      end
    end
  endtask

  initial begin
    la_snap = '0;
    test_reset();
    test_write_sel();
    test_edge_irq();
    test_w1c_collision();
    test_iena_off();
    test_unmapped();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/la_wb_cap.md
Name: la_wb_cap

Overview:
- Parametrised successor to the logic-analyser Wishbone slave.
- Provides per-bit LA output data, output-enable and input-enable registers for an arbitrary LA width.
- Adds a synchronised input-sample register, sticky rising-edge capture with write-1-to-clear, and a maskable interrupt.
- Sits on the management Wishbone bus between the SoC core and the user-project LA pins.

Parameters:
- LA_WIDTH, 128, LA bit count; multiple of 32, range 32..2048. NWORDS = LA_WIDTH/32.
- BASE_ADR, 32'h2200_0000, bus base address; only bits [31:12] are compared.
- SYNC_STAGES, 2, input synchroniser depth; range 2..3.

Ports:
- wb_clk_i  in  1  bus/system clock.
- wb_rst_i  in  1  reset, synchronous, active-low.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lane selects.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data.
- la_data_in  in  LA_WIDTH  asynchronous LA inputs from the user project.
- la_data_o  out  LA_WIDTH  LA output data.
- la_oenb_o  out  LA_WIDTH  output enable, active-low.
- la_iena_o  out  LA_WIDTH  input enable, 1 = input sampled.
- irq_o  out  1  level interrupt.

Behaviour:
- Address decode: hit = (wb_adr_i[31:12] == BASE_ADR[31:12]). bank = wb_adr_i[11:8]. word = wb_adr_i[7:2].
- Register banks (word w covers bits [32w+31:32w]):
  - bank 0 DATA, RW.
  - bank 1 OENB, RW.
  - bank 2 IENA, RW.
  - bank 3 IN, RO.
  - bank 4 EDGE, RW1C.
  - bank 5 IRQEN, RW.
- Unmapped accesses: bank > 5, or word >= NWORDS, or a hit with any undecoded combination. These are acked; reads return 0 and writes are ignored. A non-hit gets no ack.
- Reset values (wb_rst_i low at a clock edge):
  - DATA = 0, OENB = all ones, IENA = 0, EDGE = 0, IRQEN = 0.
  - Synchroniser and previous-sample flops = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq_o = 0.
- Handshake:
  - A request is accepted on the edge where stb & cyc & hit & !wb_ack_o.
  - wb_ack_o is high for exactly the following cycle, then low for at least one cycle. Back-to-back accesses therefore take 2 cycles each.
  - Read data is registered and valid while wb_ack_o = 1. wb_dat_o returns to 0 when ack drops.
  - If stb or cyc drops before ack, ack still pulses once and the register update still occurs.
- Writes take effect at the acceptance edge, so la_data_o, la_oenb_o and la_iena_o change in the same cycle ack rises.
  - Byte lanes are honoured per wb_sel_i bit; sel = 0 writes nothing but still acks.
  - IN writes are ignored.
  - EDGE write: each written 1 clears that bit; written 0 leaves it unchanged.
- Input path:
  - sync = SYNC_STAGES-flop chain of la_data_in. IN = sync_out & IENA.
  - prev = IN delayed one cycle.
  - EDGE[i] sets when IN[i] & !prev[i].
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
- Latency: a 0->1 on la_data_in (IENA = 1) is visible in IN after SYNC_STAGES edges. EDGE sets one edge later, and irq_o one edge after that.
- irq_o = registered |(EDGE & IRQEN). It deasserts one cycle after the last contributing bit is cleared or masked.
- Clearing IENA[i] forces IN[i] = 0 and produces no edge. Re-enabling while the input is high creates an edge (documented, intended).
- Reset asserted mid-transfer: any pending ack is dropped, all registers take reset values, and the in-flight write is lost.

Decomposition:
- la_wb_pkg:
  - Bank offset constants: BANK_DATA = 0, BANK_OENB = 1, BANK_IENA = 2, BANK_IN = 3, BANK_EDGE = 4, BANK_IRQEN = 5.
  - Field positions: ADR_BANK_LSB = 8, ADR_WORD_LSB = 2.
  - Function for the byte-masked write merge.
- Sub-module la_sync_edge (parametrised width and stages): synchroniser, IENA gating, previous-sample register, rising-edge pulse output. la_wb_cap holds the sticky EDGE register and W1C logic.

Test Plan:
- Reset, then read all banks at word 0 and word NWORDS-1 -> DATA/IENA/EDGE/IRQEN = 0, OENB = 32'hFFFF_FFFF, IN = 0; each ack is a one-cycle pulse.
- Write DATA word 3 = 32'hDEAD_BEEF with sel = 4'b0101, then read back -> 32'h00AD_00EF; la_data_o[127:96] matches at the ack cycle.
- IENA word 0 = 1. Drive la_data_in[0] 0->1 -> IN word 0 bit 0 = 1 after 2 edges, EDGE bit 0 = 1 next edge. irq_o stays 0 until IRQEN bit 0 is set, then goes 1 one cycle later.
- Hold the input high. W1C EDGE word 0 with 32'h1 in the same cycle a new edge arrives on bit 0 -> bit stays 1. Clear with no edge -> bit 0 = 0, irq_o falls next cycle.
- IENA = 0 with toggling la_data_in -> IN = 0, EDGE = 0, irq_o = 0. Read of bank 6, or of word NWORDS -> ack, data 0. Address 32'h3000_0000 -> no ack (bench times out after 20 cycles).
- Assert wb_rst_i low during a pending DATA write -> ack never rises and DATA stays 0 after reset.
